// File: rtl/aes_key_sched.sv
// AES key expansion for 128/192/256-bit keys with forward/reverse round-key readout.
// Define AES_KS_CACHE_EN to skip re-expansion when the same key is restarted in READY.
module aes_ks_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  // Entry 0 sits in the top byte, so byte a lives at bit offset 8*(255-a).
  assign s_o = SBOX[{~a_i, 3'b000} +: 8];
endmodule

module aes_key_sched #(
  parameter int KEY_SIZE = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [KEY_SIZE-1:0] key_i,
  input  logic                dir_i,
  input  logic                rk_req_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                ready_o,
  output logic [127:0]        rk_o,
  output logic                rk_valid_o,
  output logic                rk_last_o,
  output logic [1:0]          state_o
);
  localparam int NK = KEY_SIZE / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, READY = 2'd2} state_e;

  state_e       state_q;
  logic [31:0]  win_q [NK];
  logic [31:0]  tbl_q [NW];
  logic [5:0]   widx_q;
  logic [2:0]   kmod_q;
  logic [3:0]   rcon_idx_q, rd_ptr_q;
  logic         rdir_q, busy_q, done_q, ready_q, rk_valid_q, rk_last_q, hit_pend_q;
  logic [127:0] rk_q;

  logic [31:0]  prev_w, sub_in, sub_out, mix_w, new_w;
  logic [7:0]   rcon;
  logic         cache_hit, start_exp, rd_dir;
  logic [3:0]   rd_rnd;
  logic [5:0]   rd_base;
  logic [127:0] rk_rd;

  always_comb begin
    rcon = 8'h00;
    case (rcon_idx_q)
      4'd0: rcon = 8'h01;
      4'd1: rcon = 8'h02;
      4'd2: rcon = 8'h04;
      4'd3: rcon = 8'h08;
      4'd4: rcon = 8'h10;
      4'd5: rcon = 8'h20;
      4'd6: rcon = 8'h40;
      4'd7: rcon = 8'h80;
      4'd8: rcon = 8'h1b;
      4'd9: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_ks_sbox u_sbox (.a_i(sub_in[8*b +: 8]), .s_o(sub_out[8*b +: 8]));
  end

  // win_q holds w[i-Nk]..w[i-1]; kmod_q tracks i mod Nk for the word being produced.
  always_comb begin
    prev_w = win_q[NK-1];
    sub_in = (kmod_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    if (kmod_q == 3'd0)                 mix_w = sub_out ^ {rcon, 24'h000000};
    else if (NK > 6 && kmod_q == 3'd4)  mix_w = sub_out;
    else                                mix_w = prev_w;
    new_w = win_q[0] ^ mix_w;
  end

  // Readout handshake: each edge in READY with rk_req_i=1 (and no start) presents one
  // round key with rk_valid_o=1; direction is latched on the first key of a sequence.
  always_comb begin
    rd_dir  = (rd_ptr_q == 4'd0) ? dir_i : rdir_q;
    rd_rnd  = rd_dir ? (4'(NR) - rd_ptr_q) : rd_ptr_q;
    rd_base = {rd_rnd, 2'b00};
    rk_rd   = {tbl_q[rd_base], tbl_q[rd_base + 6'd1], tbl_q[rd_base + 6'd2], tbl_q[rd_base + 6'd3]};
  end

`ifdef AES_KS_CACHE_EN
  logic [KEY_SIZE-1:0] key_c_q;
  assign cache_hit = (state_q == READY) && (key_i == key_c_q);
`else
  assign cache_hit = 1'b0;
`endif
  assign start_exp = start_i && !cache_hit;

  always_ff @(posedge clk_i) begin
    if (start_exp) begin
      for (int j = 0; j < NK; j++) begin
        win_q[j] <= key_i[KEY_SIZE-1-32*j -: 32];
        tbl_q[j] <= key_i[KEY_SIZE-1-32*j -: 32];
      end
`ifdef AES_KS_CACHE_EN
      key_c_q <= key_i;
`endif
    end else if (state_q == EXPAND) begin
      for (int j = 0; j < NK - 1; j++) win_q[j] <= win_q[j+1];
      win_q[NK-1]    <= new_w;
      tbl_q[widx_q]  <= new_w;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      widx_q     <= 6'd0;
      kmod_q     <= 3'd0;
      rcon_idx_q <= 4'd0;
      rd_ptr_q   <= 4'd0;
      rdir_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
      hit_pend_q <= 1'b0;
      rk_q       <= 128'd0;
    end else begin
      done_q     <= 1'b0;
      hit_pend_q <= 1'b0;
      if (start_i) begin
        rk_valid_q <= 1'b0;
        rk_last_q  <= 1'b0;
        rd_ptr_q   <= 4'd0;
        if (cache_hit) begin
          hit_pend_q <= 1'b1;
        end else begin
          state_q    <= EXPAND;
          busy_q     <= 1'b1;
          ready_q    <= 1'b0;
          widx_q     <= 6'(NK);
          kmod_q     <= 3'd0;
          rcon_idx_q <= 4'd0;
        end
      end else begin
        if (hit_pend_q) done_q <= 1'b1;
        case (state_q)
          EXPAND: begin
            widx_q <= widx_q + 6'd1;
            kmod_q <= (kmod_q == 3'(NK-1)) ? 3'd0 : kmod_q + 3'd1;
            if (kmod_q == 3'd0) rcon_idx_q <= rcon_idx_q + 4'd1;
            if (widx_q == 6'(NW-1)) begin
              state_q <= READY;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              ready_q <= 1'b1;
            end
          end
          READY: begin
            if (rk_req_i) begin
              rk_q       <= rk_rd;
              rk_valid_q <= 1'b1;
              rk_last_q  <= (rd_ptr_q == 4'(NR));
              rdir_q     <= rd_dir;
              rd_ptr_q   <= (rd_ptr_q == 4'(NR)) ? 4'd0 : rd_ptr_q + 4'd1;
            end else begin
              rk_valid_q <= 1'b0;
              rk_last_q  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign ready_o    = ready_q;
  assign rk_o       = rk_q;
  assign rk_valid_o = rk_valid_q;
  assign rk_last_o  = rk_last_q;
  assign state_o    = state_q;
endmodule

// File: tb/tb_aes_key_sched.sv
// Bench for aes_key_sched: 128/192/256-bit instances, scoreboarded round-key readout
// against an independent FIPS-197 model, plus known-answer, abort and reset checks.
module tb_aes_key_sched;
  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   start_s, dir_s, req_s, busy_s, done_s, ready_s, valid_s, last_s;
  logic [255:0] key_s [3];
  logic [127:0] rk_s [3];
  logic [1:0]   st_s [3];
  logic [127:0] exp_q [$];
  logic [127:0] got [15];
  logic [7:0]   sb [256];
  logic [255:0] k128a, k128b, k192, k256, kr, kr2;
  logic         seen_busy, seen_valid;
  int           n_cmp = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  aes_key_sched #(.KEY_SIZE(128)) u128 (
    .clk_i(clk), .rst_i(rst), .start_i(start_s[0]), .key_i(key_s[0][255:128]),
    .dir_i(dir_s[0]), .rk_req_i(req_s[0]), .busy_o(busy_s[0]), .done_o(done_s[0]),
    .ready_o(ready_s[0]), .rk_o(rk_s[0]), .rk_valid_o(valid_s[0]), .rk_last_o(last_s[0]),
    .state_o(st_s[0]));
  aes_key_sched #(.KEY_SIZE(192)) u192 (
    .clk_i(clk), .rst_i(rst), .start_i(start_s[1]), .key_i(key_s[1][255:64]),
    .dir_i(dir_s[1]), .rk_req_i(req_s[1]), .busy_o(busy_s[1]), .done_o(done_s[1]),
    .ready_o(ready_s[1]), .rk_o(rk_s[1]), .rk_valid_o(valid_s[1]), .rk_last_o(last_s[1]),
    .state_o(st_s[1]));
  aes_key_sched #(.KEY_SIZE(256)) u256 (
    .clk_i(clk), .rst_i(rst), .start_i(start_s[2]), .key_i(key_s[2]),
    .dir_i(dir_s[2]), .rk_req_i(req_s[2]), .busy_o(busy_s[2]), .done_o(done_s[2]),
    .ready_o(ready_s[2]), .rk_o(rk_s[2]), .rk_valid_o(valid_s[2]), .rk_last_o(last_s[2]),
    .state_o(st_s[2]));

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Reference expansion; key is left-aligned in 256 bits.
  function automatic logic [127:0] model_rk(input logic [255:0] key, input int nk, input int r);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int k, input logic [255:0] key);
    key_s[k]   = key;
    start_s[k] = 1'b1;
    step();
    start_s[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int exp_c, input string tag);
    int c = 0;
    seen_busy  = busy_s[k];
    seen_valid = valid_s[k];
    while (done_s[k] !== 1'b1 && c < 200) begin
      step();
      c++;
      seen_busy  = seen_busy | busy_s[k];
      seen_valid = seen_valid | valid_s[k];
    end
    req_s[k] = 1'b0;
    chk(tag, 128'(c), 128'(exp_c));
    chk({tag, "_ready"}, 128'(ready_s[k]), 128'd1);
    chk({tag, "_busy"}, 128'(busy_s[k]), 128'd0);
    step();
    chk({tag, "_done_pulse"}, 128'(done_s[k]), 128'd0);
  endtask

  task automatic read_seq(input int k, input logic d, input int nk, input logic [255:0] key,
                          input int n);
    int nr = nk + 6;
    int r;
    dir_s[k] = d;
    req_s[k] = 1'b1;
    for (int j = 0; j < n; j++) begin
      r = d ? nr - j : j;
      exp_q.push_back(model_rk(key, nk, r));
      step();
      if (j == 0) dir_s[k] = ~d;
      got[j] = rk_s[k];
      chk("rk_valid", 128'(valid_s[k]), 128'd1);
      chk("rk", rk_s[k], exp_q.pop_front());
      chk("rk_last", 128'(last_s[k]), 128'(j == nr));
    end
    req_s[k] = 1'b0;
    step();
    chk("rk_valid_fall", 128'(valid_s[k]), 128'd0);
    chk("rk_hold", rk_s[k], model_rk(key, nk, d ? nr - (n - 1) : n - 1));
  endtask

  initial begin
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
              {inv[3:0], inv[7:4]} ^ 8'h63;
    end

    rst = 1'b1; start_s = '0; dir_s = '0; req_s = '0;
    for (int k = 0; k < 3; k++) key_s[k] = '0;
    step(); step();
    for (int k = 0; k < 3; k++) begin
      chk("rst_rk", rk_s[k], 128'd0);
      chk("rst_flags", 128'({busy_s[k], done_s[k], ready_s[k], valid_s[k], last_s[k]}), 128'd0);
      chk("rst_state", 128'(st_s[k]), 128'd0);
    end
    rst = 1'b0;
    step();
    req_s = 3'b111;
    step();
    chk("idle_req_ignored", 128'(valid_s), 128'd0);
    req_s = 3'b000;

    k128a = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    do_start(0, k128a);
    chk("start_busy", 128'(busy_s[0]), 128'd1);
    chk("start_ready", 128'(ready_s[0]), 128'd0);
    chk("start_state", 128'(st_s[0]), 128'd1);
    wait_done(0, 40, "done128");
    read_seq(0, 1'b0, 4, k128a, 11);
    chk("kat128_rk0", got[0], 128'h000102030405060708090a0b0c0d0e0f);
    chk("kat128_rk10", got[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    k128b = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    do_start(0, k128b);
    wait_done(0, 40, "done128b");
    read_seq(0, 1'b1, 4, k128b, 11);
    chk("kat128_rev_first", got[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("kat128_rev_last", got[10], 128'h2b7e151628aed2a6abf7158809cf4f3c);

    k192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    do_start(1, k192);
    wait_done(1, 46, "done192");
    read_seq(1, 1'b0, 6, k192, 13);
    chk("kat192_rk12", got[12], 128'ha4970a331a78dc09c418c271e3a41d5d);

    k256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    do_start(2, k256);
    wait_done(2, 52, "done256");
    read_seq(2, 1'b1, 8, k256, 15);
    chk("kat256_rev_first", got[0], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    for (int i = 0; i < 8; i++) kr[255-32*i -: 32] = $urandom;
    do_start(2, k256);
    repeat (19) step();
    chk("restart_no_done", 128'(done_s[2]), 128'd0);
    do_start(2, kr);
    wait_done(2, 52, "restart256");
    read_seq(2, 1'b0, 8, kr, 15);

    kr2 = '0;
    for (int i = 0; i < 4; i++) kr2[255-32*i -: 32] = $urandom;
    dir_s[0] = 1'b0;
    req_s[0] = 1'b1;
    step();
    chk("pre_abort_valid", 128'(valid_s[0]), 128'd1);
    step();
    do_start(0, kr2);
    chk("start_wins_valid", 128'(valid_s[0]), 128'd0);
    chk("start_wins_busy", 128'(busy_s[0]), 128'd1);
    wait_done(0, 40, "abort128");
    chk("req_in_expand", 128'(seen_valid), 128'd0);
    read_seq(0, 1'b0, 4, kr2, 11);

    read_seq(0, 1'b0, 4, kr2, 3);
    do_start(0, kr2);
`ifdef AES_KS_CACHE_EN
    chk("hit_ready", 128'(ready_s[0]), 128'd1);
    wait_done(0, 1, "cache_hit");
    chk("hit_busy_seen", 128'(seen_busy), 128'd0);
`else
    chk("repeat_busy", 128'(busy_s[0]), 128'd1);
    wait_done(0, 40, "repeat128");
    chk("repeat_busy_seen", 128'(seen_busy), 128'd1);
`endif
    read_seq(0, 1'b1, 4, kr2, 11);

    dir_s[0] = 1'b0;
    req_s[0] = 1'b1;
    step(); step();
    chk("pre_rst_valid", 128'(valid_s[0]), 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rk", rk_s[0], 128'd0);
    chk("async_rst_flags",
        128'({busy_s[0], done_s[0], ready_s[0], valid_s[0], last_s[0]}), 128'd0);
    step();
    rst = 1'b0;
    step(); step();
    chk("post_rst_req_ignored", 128'(valid_s[0]), 128'd0);
    chk("post_rst_state", 128'(st_s[0]), 128'd0);
    req_s[0] = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/aes_key_sched.md
AES_KEY_SCHED -- requirements
Module: aes_key_sched

Interface
- REQ-001 Parameter KEY_SIZE, default 256: key length in bits; legal values 128, 192 and 256. Derived values: Nk = KEY_SIZE/32; Nr = Nk+6; W = 4(Nr+1)-Nk.
- REQ-002 clk  input  1  single clock; all flops rising-edge.
- REQ-003 rst  input  1  reset, asynchronous and active-high.
- REQ-004 start  input  1  pulse that captures key and begins expansion.
- REQ-005 key  input  KEY_SIZE  cipher key, FIPS-197 byte order, MSB = byte 0.
- REQ-006 dir  input  1  readout order: 0 = forward (rk0..rkNr, encrypt); 1 = reverse (rkNr..rk0, decrypt).
- REQ-007 rk_req  input  1  request for the next round key.
- REQ-008 busy  output  1  expansion in progress.
- REQ-009 done  output  1  one-cycle pulse when the key table becomes valid.
- REQ-010 ready  output  1  key table valid; readout permitted.
- REQ-011 rk  output  128  round key, registered.
- REQ-012 rk_valid  output  1  rk is valid this cycle.
- REQ-013 rk_last  output  1  rk is the final key of the current sequence.

Function
- REQ-014 FSM states: IDLE, EXPAND, READY. Transitions: IDLE->EXPAND on start; EXPAND->READY after W words; READY->EXPAND on start; any state->IDLE on rst.
- REQ-015 Start handling: at the edge sampling start, load words w[0..Nk-1] from key; set busy=1, ready=0, rk_valid=0.
- REQ-016 Expansion rate: one word w[i] per clock, i = Nk..4(Nr+1)-1, per FIPS-197 (RotWord/SubWord/Rcon; for Nk=8, SubWord only when i mod 8 = 4). Word count W = 40 / 46 / 52 for KEY_SIZE 128 / 192 / 256.
- REQ-017 SubWord: four instances of the codebase S-box; Rcon is an internal 10-entry table.
- REQ-018 Completion timing: done=1 and ready=1 exactly W edges after the start edge; busy falls at the same edge; done lasts one cycle.
- REQ-019 Readout request: in READY, rk_req=1 at an edge loads rk with the key at the read pointer and sets rk_valid=1 at that edge. rk_valid falls at the next edge without rk_req.
- REQ-020 Back-to-back readout: rk_req held high yields Nr+1 consecutive valid keys, one per cycle.
- REQ-021 Sequence order: dir is sampled only on the first request of a sequence; later changes within the sequence are ignored. rk_last=1 with the (Nr+1)th key; the pointer then rewinds, so the next request starts a new sequence.
- REQ-022 rk_req outside READY is ignored; no output changes.
- REQ-023 start during EXPAND aborts the expansion and restarts with the new key; W is recounted from that edge.
- REQ-024 start during READY aborts any readout (rk_valid=0, pointer rewound) and re-expands.
- REQ-025 start and rk_req in the same cycle: start wins; the request is dropped.
- REQ-026 rk holds its last value while rk_valid=0.

Reset
- REQ-027 rst=1 asynchronously forces IDLE with busy=0, done=0, ready=0, rk=0, rk_valid=0, rk_last=0, read pointer=0 and Rcon index=0.
- REQ-028 Key table contents are undefined after reset. rst during EXPAND or readout discards all progress; a new start is required.

Configuration
- REQ-029 Macro AES_KS_CACHE_EN defined: the block stores the last expanded key. A start in READY with key equal to the stored key skips expansion: busy stays 0, done pulses one edge after start, ready stays 1, and the read pointer rewinds.
- REQ-030 Macro AES_KS_CACHE_EN undefined: every start performs the full W-cycle expansion; no key comparator or key storage beyond the table is built.

Verification
- REQ-031 KEY_SIZE=128, key 000102030405060708090a0b0c0d0e0f, dir=0, rk_req held -> done 40 cycles after start; rk0 = key; rk10 = 13111d7fe3944a17f307a78b4d2b30c5 with rk_last=1.
- REQ-032 KEY_SIZE=128, key 2b7e151628aed2a6abf7158809cf4f3c, dir=1 -> first rk = d014f9a8c9ee2589e13f0cc8b6630ca6; 11th rk = key with rk_last=1.
- REQ-033 KEY_SIZE=192, key 000102...1617, dir=0 -> done at 46 cycles; rk12 = a4970a331a78dc09c418c271e3a41d5d.
- REQ-034 KEY_SIZE=256, key 000102...1e1f, dir=1 -> done at 52 cycles; first rk = 24fc79ccbf0979e9371ac23c6d68de36. Second test: start reissued at cycle 20 of expansion -> done 52 cycles after the second start.
- REQ-035 rst asserted mid-readout -> all outputs 0 immediately; rk_req ignored until a new start. With AES_KS_CACHE_EN, a repeat start with the same key -> done after 1 cycle, busy never 1.
